fphub_to_ieee: RTL
==================

# fphub_to_ieee

Sequential decoder that turns a HUB-format floating-point word (as produced by the FPHUB adder datapath) back into a standard IEEE-754 binary word of configurable width. It sits at the output boundary of the HUB arithmetic cluster. It applies round-to-nearest-even, rebiases the exponent and denormalises underflowing results with an iterative one-bit-per-cycle aligner. A valid/ready handshake on each side carries one conversion in flight.

## Interface
- M, 23, HUB fraction bits (explicit)
- E, 8, HUB exponent bits
- OM, 23, IEEE output fraction bits (≥1)
- OE, 8, IEEE output exponent bits (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts input; high only in IDLE
- in_data  in  E+M+1  HUB word {s, Ex, f}
- out_valid  out  1  result valid; high only in HOLD
- out_ready  in  1  consumer accepts result
- out_data  out  OE+OM+1  IEEE word {s, Eo, fo}
- flag_overflow  out  1  result became ±inf from a finite input
- flag_underflow  out  1  tiny before rounding, and inexact
- flag_inexact  out  1  nonzero bits discarded

## Operation
- HUB decode: value = (-1)^s · 2^(Ex−Bin) · 1.f1, with M+1 fraction bits and an implicit LSB of 1. Bin = 2^(E−1)−1 and Bout = 2^(OE−1)−1.
- Special inputs:
  - Ex=0 → ±0.
  - Ex=all-ones with f=0 → ±inf.
  - Ex=all-ones with f≠0 → canonical qNaN: s=0, Eo all-ones, fo MSB=1, rest 0.
  - No flags are raised for special inputs.
- Target exponent: T = Ex − Bin + Bout, computed signed with width max(E,OE)+2.
  - T ≥ 2^OE−1 → ±inf, flag_overflow=1, flag_inexact=1.
  - T ≤ 0 → tiny. The shift count is k = min(1−T, OM+2).
- Significand register: S = {1, f, 1} extended by zero-padding to OM+2 fraction bits when OM+1 > M+1. A sticky bit accumulates the OR of every bit shifted or truncated away.
- ALIGN: S shifts right by 1 each cycle, sticky |= the shifted-out bit. The shift counter decrements to 0.
- ROUND:
  - Keep OM fraction bits. Guard = next bit. Sticky |= all bits below guard.
  - Increment when guard & (sticky | lsb).
  - Carry out of a normal significand → fraction 0, exponent+1. If the exponent reaches all-ones → ±inf, flag_overflow=1.
  - A tiny result that rounds up to 1.0 gets Eo=1.
  - A tiny result otherwise gets Eo=0.
- Flags: flag_inexact = guard|sticky. flag_underflow = tiny & inexact. The sign is passed through on every finite or infinite result.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture the input and classify it. Special → HOLD with the result loaded. k>0 → ALIGN. Otherwise → ROUND.
  - ALIGN: runs k cycles, then → ROUND.
  - ROUND: one cycle, loads out_data and flags, → HOLD.
  - HOLD: out_valid=1. out_data and flags stay stable until out_ready. On out_ready → IDLE.
- No input is accepted while busy; there is no skid buffer.

## Timing
- Reset (async assert, sync deassert via clk):
  - State returns to IDLE.
  - out_valid=0, out_data=0, all flags=0.
  - in_ready=1 as soon as rst_n is low.
- Reset mid-operation abandons the word; no output is produced.
- Handshake at edge t (in_valid & in_ready). out_valid rises at:
  - t+1 for special inputs;
  - t+2 for normal finite results;
  - t+2+k for tiny results.
- out_data and the flags change only on the edge that enters HOLD.
- HOLD→IDLE happens on the edge where out_valid & out_ready. in_ready is high on the following cycle. Minimum issue interval is 3 cycles for normal inputs.
- in_data changes while busy are ignored.

## Test plan
- M=23, E=8, OM=23, OE=8. Input 0x3F800000 (1+2^-24, a tie with even lsb) → 0x3F800000 with inexact=1, out_valid two cycles after acceptance. Input 0x3F800001 → 0x3F800002 with inexact=1.
- Same configuration, input 0x7F7FFFFF → rounding carry overflows → 0x7F800000 with overflow=1 and inexact=1.
- Special inputs, same configuration:
  - 0x80000000 → 0x80000000, flags 0, out_valid at t+1.
  - 0xFF800000 → 0xFF800000.
  - 0x7F800001 → 0x7FC00000.
- M=23, E=8, OM=10, OE=5:
  - Input 0x38000000 (T=0, k=1) → one ALIGN cycle, out_data 0x0200, underflow=1, inexact=1, out_valid at t+3.
  - Input 0x30000000 → k capped at 12 → 0x0000, underflow=1.
- Backpressure: hold out_ready low for 5 cycles in HOLD → out_data and flags stable, in_ready=0, a new in_valid is ignored. Then pulse out_ready → in_ready=1 on the next cycle.
- Assert rst_n low during ALIGN → out_valid=0 and in_ready=1 immediately. After release, input 0x3F800000 converts normally.

Source files
------------

// File: rtl/fphub_to_ieee_if.sv
// Handshake bundle for the HUB-to-IEEE output converter.
// Input side carries HUB words in; output side carries IEEE words and flags out.
interface fphub_to_ieee_if #(
  parameter int M  = 23,
  parameter int E  = 8,
  parameter int OM = 23,
  parameter int OE = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [E+M:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OE+OM:0]   out_data;
  logic             flag_overflow;
  logic             flag_underflow;
  logic             flag_inexact;

  // Converter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output flag_overflow, flag_underflow, flag_inexact
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fphub_to_ieee.sv
// HUB floating-point to IEEE-754 converter.
// Rebiases the exponent, denormalises tiny results one bit per cycle,
// rounds to nearest-even and raises overflow/underflow/inexact flags.
// One conversion in flight; result is held until the consumer takes it.
module fphub_to_ieee #(
  parameter int M  = 23,
  parameter int E  = 8,
  parameter int OM = 23,
  parameter int OE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  fphub_to_ieee_if.slave   bus
);

  // Significand fraction width: wide enough for all HUB bits and for
  // OM kept bits plus guard plus at least one sticky bit.
  localparam int FW  = ((M + 1) > (OM + 2)) ? (M + 1) : (OM + 2);
  localparam int SW  = FW + 1;
  localparam int PAD = FW - (M + 1);
  localparam int TW  = ((E > OE) ? E : OE) + 2;
  localparam int CW  = $clog2(OM + 3);
  localparam int GI  = FW - OM - 1;

  localparam logic signed [TW-1:0] BIN    = TW'((1 << (E - 1)) - 1);
  localparam logic signed [TW-1:0] BOUT   = TW'((1 << (OE - 1)) - 1);
  localparam logic signed [TW-1:0] T_INF  = TW'((1 << OE) - 1);
  localparam logic signed [TW-1:0] T_ZERO = '0;
  localparam logic signed [TW-1:0] T_ONE  = TW'(1);
  localparam logic signed [TW-1:0] K_MAX  = TW'(OM + 2);
  localparam logic [OM-1:0]        QFRAC  = OM'(1) << (OM - 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    ROUND,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [OE-1:0]     exp_q, exp_d;
  logic              tiny_q, tiny_d;
  logic              huge_q, huge_d;
  logic [SW-1:0]     sig_q, sig_d;
  logic              sticky_q, sticky_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OE+OM:0]    odata_q, odata_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              inx_q, inx_d;

  // Input field split and classification helpers
  logic                  in_s;
  logic [E-1:0]          in_ex;
  logic [M-1:0]          in_f;
  logic signed [TW-1:0]  t_val;
  logic signed [TW-1:0]  one_m_t;
  logic [CW-1:0]         k_val;
  logic [SW-1:0]         sig_init;

  // Rounding datapath signals
  logic [OM-1:0]  kept;
  logic           intb;
  logic           guard;
  logic           st_all;
  logic           inc;
  logic [OM+1:0]  sum;
  logic [OE-1:0]  exp_inc;
  logic [OE+OM:0] rnd_data;
  logic           rnd_ovf;

  // Decode the incoming HUB word: target exponent, shift count, significand
  always_comb begin
    in_s     = bus.in_data[E+M];
    in_ex    = bus.in_data[E+M-1:M];
    in_f     = bus.in_data[M-1:0];
    t_val    = $signed({{(TW-E){1'b0}}, in_ex}) - BIN + BOUT;
    one_m_t  = T_ONE - t_val;
    k_val    = (one_m_t > K_MAX) ? CW'(K_MAX) : CW'(one_m_t);
    // {1, f, implicit 1} left-justified in the fraction field
    sig_init = SW'({1'b1, in_f, 1'b1}) << PAD;
  end

  // Round-to-nearest-even on the aligned significand and pack the IEEE word
  always_comb begin
    kept     = sig_q[FW-1 -: OM];
    intb     = sig_q[FW];
    guard    = sig_q[GI];
    st_all   = sticky_q | (|sig_q[GI-1:0]);
    inc      = guard & (st_all | kept[0]);
    sum      = {1'b0, intb, kept} + (OM + 2)'(inc);
    exp_inc  = exp_q + OE'(1);
    rnd_ovf  = 1'b0;
    rnd_data = '0;
    if (tiny_q) begin
      // Carry into the integer position promotes to the smallest normal
      rnd_data = {sign_q, {(OE-1){1'b0}}, sum[OM], sum[OM-1:0]};
    end else if (huge_q) begin
      rnd_data = {sign_q, {OE{1'b1}}, {OM{1'b0}}};
      rnd_ovf  = 1'b1;
    end else if (sum[OM+1]) begin
      if (exp_inc == '1) begin
        rnd_data = {sign_q, {OE{1'b1}}, {OM{1'b0}}};
        rnd_ovf  = 1'b1;
      end else begin
        rnd_data = {sign_q, exp_inc, sum[OM-1:0]};
      end
    end else begin
      rnd_data = {sign_q, exp_q, sum[OM-1:0]};
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    tiny_d   = tiny_q;
    huge_d   = huge_q;
    sig_d    = sig_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    odata_d  = odata_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d = in_s;
          if (in_ex == '0) begin
            odata_d = {in_s, {(OE+OM){1'b0}}};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            inx_d   = 1'b0;
            state_d = HOLD;
          end else if (in_ex == '1) begin
            odata_d = (in_f == '0) ? {in_s, {OE{1'b1}}, {OM{1'b0}}}
                                   : {1'b0, {OE{1'b1}}, QFRAC};
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            inx_d   = 1'b0;
            state_d = HOLD;
          end else begin
            sig_d    = sig_init;
            sticky_d = 1'b0;
            exp_d    = t_val[OE-1:0];
            huge_d   = (t_val >= T_INF);
            tiny_d   = (t_val <= T_ZERO);
            cnt_d    = k_val;
            state_d  = (t_val <= T_ZERO) ? ALIGN : ROUND;
          end
        end
      end
      ALIGN: begin
        sig_d    = sig_q >> 1;
        sticky_d = sticky_q | sig_q[0];
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ROUND;
      end
      ROUND: begin
        odata_d = rnd_data;
        ovf_d   = rnd_ovf;
        inx_d   = guard | st_all | huge_q;
        unf_d   = tiny_q & (guard | st_all);
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      tiny_q   <= 1'b0;
      huge_q   <= 1'b0;
      sig_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      odata_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      tiny_q   <= tiny_d;
      huge_q   <= huge_d;
      sig_q    <= sig_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      odata_q  <= odata_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.out_valid      = (state_q == HOLD);
  assign bus.out_data       = odata_q;
  assign bus.flag_overflow  = ovf_q;
  assign bus.flag_underflow = unf_q;
  assign bus.flag_inexact   = inx_q;

endmodule
